// File: rtl/cricket_pkg.sv
// Shared definitions for the cricket scoreboard blocks: score-word layout,
// innings state encoding and winner encoding.
package cricket_pkg;

    localparam int SCORE_W  = 12;
    localparam int RUNS_MSB = 11;
    localparam int RUNS_LSB = 4;
    localparam int WKT_MSB  = 3;
    localparam int WKT_LSB  = 0;

    typedef enum logic [1:0] {
        INN1  = 2'd0,
        BREAK = 2'd1,
        INN2  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic WIN_TEAM1 = 1'b0;
    localparam logic WIN_TEAM2 = 1'b1;

    function automatic logic [RUNS_MSB-RUNS_LSB:0] runs_of(input logic [SCORE_W-1:0] word);
        return word[RUNS_MSB:RUNS_LSB];
    endfunction

    function automatic logic [WKT_MSB-WKT_LSB:0] wkts_of(input logic [SCORE_W-1:0] word);
        return word[WKT_MSB:WKT_LSB];
    endfunction

endpackage

// File: rtl/over_counter.sv
// Per-team legal-ball counter: saturating ball total plus overs/ball-in-over
// tracked by a wrapping sub-counter rather than a divider.
module over_counter #(
    parameter int BALLS_PER_OVER = 6,
    parameter int BALL_LIMIT     = 120
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_inc,
    input  logic       i_clr,
    output logic [6:0] o_balls,
    output logic [4:0] o_overs,
    output logic [2:0] o_ball_in_over
);

    localparam logic [6:0] LIMIT    = 7'(BALL_LIMIT);
    localparam logic [2:0] LAST_BIO = 3'(BALLS_PER_OVER - 1);

    logic [6:0] r_balls;
    logic [4:0] r_overs;
    logic [2:0] r_ball_in_over;
    logic       w_step;

    assign w_step = i_inc && (r_balls != LIMIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_balls        <= '0;
            r_overs        <= '0;
            r_ball_in_over <= '0;
        end else begin
            if (w_step)
                r_balls <= r_balls + 7'd1;
            // clr only resets the over view; the ball total is the team's record
            if (i_clr) begin
                r_overs        <= '0;
                r_ball_in_over <= '0;
            end else if (w_step) begin
                if (r_ball_in_over == LAST_BIO) begin
                    r_ball_in_over <= '0;
                    r_overs        <= r_overs + 5'd1;
                end else begin
                    r_ball_in_over <= r_ball_in_over + 3'd1;
                end
            end
        end
    end

    assign o_balls        = r_balls;
    assign o_overs        = r_overs;
    assign o_ball_in_over = r_ball_in_over;

endmodule

// File: rtl/innings_referee.sv
// Innings sequencer and result adjudicator: accepts deliveries, evaluates the
// score words one edge later, latches the chase target and declares the result.
module innings_referee
    import cricket_pkg::*;
#(
    parameter int MAX_OVERS      = 20,
    parameter int BALLS_PER_OVER = 6,
    parameter int MAX_WICKETS    = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_delivery,
    input  logic               i_team_sel,
    input  logic [SCORE_W-1:0] i_team1_data,
    input  logic [SCORE_W-1:0] i_team2_data,
    output logic [6:0]         o_team1_balls,
    output logic [6:0]         o_team2_balls,
    output logic [4:0]         o_overs,
    output logic [2:0]         o_ball_in_over,
    output logic [8:0]         o_target,
    output logic               o_inning_over,
    output logic               o_game_over,
    output logic               o_winner,
    output logic               o_tie
);

    localparam int         BALL_LIMIT = MAX_OVERS * BALLS_PER_OVER;
    localparam logic [6:0] LIMIT      = 7'(BALL_LIMIT);
    localparam logic [3:0] WKT_OUT    = 4'(MAX_WICKETS);

    state_t     r_state, w_next_state;
    logic       r_eval_pending;
    logic [8:0] r_target;
    logic       r_inning_over, r_game_over, r_winner, r_tie;

    logic       w_accept, w_inc1, w_inc2, w_clr2;
    logic [6:0] w_balls1, w_balls2;
    logic [4:0] w_overs1, w_overs2;
    logic [2:0] w_bio1, w_bio2;
    logic [8:0] w_runs1_ext, w_runs2_ext;
    logic       w_inn1_end, w_chase_won, w_inn2_end, w_level;
    logic       w_load_target, w_set_result, w_next_winner, w_next_tie;

    assign w_accept = i_delivery && !r_eval_pending &&
                      (((r_state == INN1) && !i_team_sel) ||
                       ((r_state == INN2) &&  i_team_sel));
    assign w_inc1   = w_accept && (r_state == INN1);
    assign w_inc2   = w_accept && (r_state == INN2);
    assign w_clr2   = (r_state == BREAK) && i_team_sel;

    over_counter #(
        .BALLS_PER_OVER (BALLS_PER_OVER),
        .BALL_LIMIT     (BALL_LIMIT)
    ) u_cnt_team1 (
        .clk            (clk),
        .reset          (reset),
        .i_inc          (w_inc1),
        .i_clr          (1'b0),
        .o_balls        (w_balls1),
        .o_overs        (w_overs1),
        .o_ball_in_over (w_bio1)
    );

    over_counter #(
        .BALLS_PER_OVER (BALLS_PER_OVER),
        .BALL_LIMIT     (BALL_LIMIT)
    ) u_cnt_team2 (
        .clk            (clk),
        .reset          (reset),
        .i_inc          (w_inc2),
        .i_clr          (w_clr2),
        .o_balls        (w_balls2),
        .o_overs        (w_overs2),
        .o_ball_in_over (w_bio2)
    );

    // Score words lag the strobe by one edge, so these are only meaningful while eval_pending
    assign w_runs1_ext = {1'b0, runs_of(i_team1_data)};
    assign w_runs2_ext = {1'b0, runs_of(i_team2_data)};
    assign w_inn1_end  = (wkts_of(i_team1_data) >= WKT_OUT) || (w_balls1 == LIMIT);
    assign w_inn2_end  = (wkts_of(i_team2_data) >= WKT_OUT) || (w_balls2 == LIMIT);
    assign w_chase_won = (w_runs2_ext >= r_target);
    assign w_level     = (w_runs2_ext == (r_target - 9'd1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= INN1;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state  = r_state;
        w_load_target = 1'b0;
        w_set_result  = 1'b0;
        w_next_winner = WIN_TEAM1;
        w_next_tie    = 1'b0;
        case (r_state)
            INN1: begin
                if (r_eval_pending && w_inn1_end) begin
                    w_next_state  = BREAK;
                    w_load_target = 1'b1;
                end
            end
            BREAK: begin
                if (i_team_sel)
                    w_next_state = INN2;
            end
            INN2: begin
                if (r_eval_pending) begin
                    if (w_chase_won) begin
                        w_next_state  = DONE;
                        w_set_result  = 1'b1;
                        w_next_winner = WIN_TEAM2;
                    end else if (w_inn2_end) begin
                        w_next_state  = DONE;
                        w_set_result  = 1'b1;
                        w_next_winner = WIN_TEAM1;
                        w_next_tie    = w_level;
                    end
                end
            end
            DONE: begin
                w_next_state = DONE;
            end
            default: begin
                w_next_state = INN1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_eval_pending <= 1'b0;
            r_target       <= '0;
            r_inning_over  <= 1'b0;
            r_game_over    <= 1'b0;
            r_winner       <= WIN_TEAM1;
            r_tie          <= 1'b0;
        end else begin
            r_eval_pending <= w_accept;
            if (w_load_target)
                r_target <= w_runs1_ext + 9'd1;
            r_inning_over <= (w_next_state == BREAK);
            r_game_over   <= (w_next_state == DONE);
            if (w_set_result) begin
                r_winner <= w_next_winner;
                r_tie    <= w_next_tie;
            end
        end
    end

    // Team 2's counters only move in INN2 and are frozen in DONE, so the mux holds last values
    assign o_overs        = ((r_state == INN2) || (r_state == DONE)) ? w_overs2 : w_overs1;
    assign o_ball_in_over = ((r_state == INN2) || (r_state == DONE)) ? w_bio2   : w_bio1;
    assign o_team1_balls  = w_balls1;
    assign o_team2_balls  = w_balls2;
    assign o_target       = r_target;
    assign o_inning_over  = r_inning_over;
    assign o_game_over    = r_game_over;
    assign o_winner       = r_winner;
    assign o_tie          = r_tie;

endmodule
